roulette_spin_ctrl: RTL

ROULETTE_SPIN_CTRL -- requirements
Module: roulette_spin_ctrl

---
 rtl/roulette_spin_ctrl_pkg.sv | 26 ++
 rtl/roulette_pos_to_number.sv | 38 +++
 rtl/roulette_spin_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/roulette_spin_ctrl_pkg.sv
// Shared types and constants for the roulette spin controller.
package roulette_spin_ctrl_pkg;

    localparam int unsigned NUM_POCKETS = 38;
    localparam int unsigned DZ_POCKET   = 19;
    localparam int unsigned POS_W       = 6;
    localparam int unsigned LFSR_W      = 16;
    localparam int unsigned DIV_W       = 16;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    // Taps for x^16+x^14+x^13+x^11+1 on a left-shifting register (bits 15,13,12,10)
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FAST = 2'd1,
        ST_SLOW = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // One Fibonacci step: shift left, XOR of tapped bits enters bit 0
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/roulette_pos_to_number.sv
// Pocket index (physical position on the wheel) to printed roulette number.
module roulette_pos_to_number
    import roulette_spin_ctrl_pkg::*;
(
    input  logic [5:0] pos,
    output logic [5:0] number,
    output logic       is_00
);

    // Double-zero wheel order, pocket 0 is "0", pocket 19 is "00" (printed as 0)
    always_comb begin
        number = 6'd0;
        is_00  = (pos == POS_W'(DZ_POCKET));
        case (pos)
            6'd0:  number = 6'd0;   6'd1:  number = 6'd28;
            6'd2:  number = 6'd9;   6'd3:  number = 6'd26;
            6'd4:  number = 6'd30;  6'd5:  number = 6'd11;
            6'd6:  number = 6'd7;   6'd7:  number = 6'd20;
            6'd8:  number = 6'd32;  6'd9:  number = 6'd17;
            6'd10: number = 6'd5;   6'd11: number = 6'd22;
            6'd12: number = 6'd34;  6'd13: number = 6'd15;
            6'd14: number = 6'd3;   6'd15: number = 6'd24;
            6'd16: number = 6'd36;  6'd17: number = 6'd13;
            6'd18: number = 6'd1;   6'd19: number = 6'd0;
            6'd20: number = 6'd27;  6'd21: number = 6'd10;
            6'd22: number = 6'd25;  6'd23: number = 6'd29;
            6'd24: number = 6'd12;  6'd25: number = 6'd8;
            6'd26: number = 6'd19;  6'd27: number = 6'd31;
            6'd28: number = 6'd18;  6'd29: number = 6'd6;
            6'd30: number = 6'd21;  6'd31: number = 6'd33;
            6'd32: number = 6'd16;  6'd33: number = 6'd4;
            6'd34: number = 6'd23;  6'd35: number = 6'd35;
            6'd36: number = 6'd14;  6'd37: number = 6'd2;
            default: number = 6'd0;
        endcase
    end

endmodule

// File: rtl/roulette_spin_ctrl.sv
// Roulette wheel spin controller: fast run, decelerating run, held result.
module roulette_spin_ctrl
    import roulette_spin_ctrl_pkg::*;
#(
    parameter int unsigned FAST_DIV   = 4,
    parameter int unsigned DIV_INC    = 2,
    parameter int unsigned STOP_DIV   = 40,
    parameter int unsigned BASE_STEPS = 76
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spin_req,
    input  logic       result_ack,
    output logic [5:0] wheel_pos,
    output logic       busy,
    output logic       result_valid,
    output logic [5:0] win_number,
    output logic       win_00
);

    state_e              state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [DIV_W-1:0]    cur_div_q, cur_div_d;
    logic [DIV_W-1:0]    fast_left_q, fast_left_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;

    logic [DIV_W-1:0]    div_c;
    logic                step_c;
    logic [POS_W-1:0]    pos_inc_c;
    logic [DIV_W-1:0]    div_grow_c;

    // Next-state, counters, wheel stepping and registered status outputs
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_next(lfsr_q);
        cnt_d       = cnt_q;
        cur_div_d   = cur_div_q;
        fast_left_d = fast_left_q;
        pos_d       = pos_q;

        div_c      = (state_q == ST_FAST) ? DIV_W'(FAST_DIV) : cur_div_q;
        step_c     = (cnt_q == div_c - DIV_W'(1));
        pos_inc_c  = (pos_q == POS_W'(NUM_POCKETS - 1)) ? '0 : pos_q + POS_W'(1);
        div_grow_c = cur_div_q + DIV_W'(DIV_INC);

        case (state_q)
            ST_IDLE: begin
                if (spin_req) begin
                    state_d     = ST_FAST;
                    fast_left_d = DIV_W'(BASE_STEPS) + DIV_W'(lfsr_q[5:0]);
                    cnt_d       = '0;
                end
            end
            ST_FAST: begin
                if (step_c) begin
                    cnt_d       = '0;
                    pos_d       = pos_inc_c;
                    fast_left_d = fast_left_q - DIV_W'(1);
                    if (fast_left_q == DIV_W'(1)) begin
                        state_d   = ST_SLOW;
                        cur_div_d = DIV_W'(FAST_DIV + DIV_INC);
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            ST_SLOW: begin
                if (step_c) begin
                    cnt_d     = '0;
                    pos_d     = pos_inc_c;
                    cur_div_d = div_grow_c;
                    if (div_grow_c > DIV_W'(STOP_DIV)) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            ST_DONE: begin
                if (result_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d  = (state_d == ST_FAST) || (state_d == ST_SLOW);
        valid_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= LFSR_SEED;
            cnt_q       <= '0;
            cur_div_q   <= '0;
            fast_left_q <= '0;
            pos_q       <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            cur_div_q   <= cur_div_d;
            fast_left_q <= fast_left_d;
            pos_q       <= pos_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
        end
    end

    assign wheel_pos    = pos_q;
    assign busy         = busy_q;
    assign result_valid = valid_q;

    roulette_pos_to_number u_pos_to_number (
        .pos    (pos_q),
        .number (win_number),
        .is_00  (win_00)
    );

endmodule
